// File: rtl/axi_pt_txn_scoreboard_if.sv
// ---------------------------------------------------------------------------
// axi_pt_txn_scoreboard_if
//   Record taps feeding the transaction scoreboard. Each channel has an
//   upstream (mst_*) and a downstream (slv_*) record stream.
//   Channel c occupies bits [c*REC_W +: REC_W] of the record buses.
//
//   Signals
//     mst_valid / slv_valid  per-channel record valid (tap -> scoreboard)
//     mst_rec   / slv_rec    packed per-channel records (tap -> scoreboard)
//     mst_ready / slv_ready  per-channel FIFO not full (scoreboard -> tap)
//
//   Modports
//     master : monitor taps that produce records
//     slave  : the scoreboard that consumes them
// ---------------------------------------------------------------------------
interface axi_pt_txn_scoreboard_if #(
  parameter int NUM_CH = 2,
  parameter int REC_W  = 76
);
  logic [NUM_CH-1:0]       mst_valid;
  logic [NUM_CH-1:0]       mst_ready;
  logic [NUM_CH*REC_W-1:0] mst_rec;
  logic [NUM_CH-1:0]       slv_valid;
  logic [NUM_CH-1:0]       slv_ready;
  logic [NUM_CH*REC_W-1:0] slv_rec;

  modport master (
    output mst_valid, mst_rec, slv_valid, slv_rec,
    input  mst_ready, slv_ready
  );

  modport slave (
    input  mst_valid, mst_rec, slv_valid, slv_rec,
    output mst_ready, slv_ready
  );
endinterface

// File: rtl/axi_pt_txn_scoreboard.sv
// ---------------------------------------------------------------------------
// axi_pt_txn_scoreboard
//   In-order transaction scoreboard placed across an AXI passthrough.
//   Upstream and downstream monitor taps push {id, addr, len[7:0], sig}
//   records per channel into per-side FIFOs. When both heads of a channel
//   are present they pop together and are compared bit-for-bit; the result
//   is registered and then folded into saturating counters and sticky flags.
//
//   Ports
//     aclk, aresetn   clock, asynchronous active-low reset
//     clr             synchronous clear of counters, flags and FIFOs
//     tap             record taps (mst_/slv_ valid, ready, rec)
//     cmp_cnt         total comparisons (saturating)
//     err_cnt         total mismatching comparisons (saturating)
//     err_ch          sticky per-channel mismatch flag
//     ovf             sticky per-channel "valid stalled 256 cycles" flag
//     idle            all FIFOs empty and no registered compare pending
//     fe_valid/fe_ch/fe_mst/fe_slv  first-error capture
//
//   Optional feature macro: SCB_FIRST_ERR_CAPTURE_EN
//     defined   : first mismatch after reset/clr is captured and frozen
//     undefined : fe_* outputs are tied to zero, no capture registers
// ---------------------------------------------------------------------------
module axi_pt_txn_scoreboard #(
  parameter int  NUM_CH  = 2,
  parameter int  ADDR_W  = 32,
  parameter int  ID_W    = 4,
  parameter int  SIG_W   = 32,
  parameter int  DEPTH   = 8,
  parameter int  CNT_W   = 16,
  localparam int REC_W   = ID_W + ADDR_W + 8 + SIG_W,
  localparam int FE_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   clr,
  axi_pt_txn_scoreboard_if.slave tap,
  output logic [CNT_W-1:0]       cmp_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [NUM_CH-1:0]      err_ch,
  output logic [NUM_CH-1:0]      ovf,
  output logic                   idle,
  output logic                   fe_valid,
  output logic [FE_CH_W-1:0]     fe_ch,
  output logic [REC_W-1:0]       fe_mst,
  output logic [REC_W-1:0]       fe_slv
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  // Side index 0 = upstream (mst), 1 = downstream (slv).
  logic             vld_in   [NUM_CH][2];
  logic [REC_W-1:0] rec_in   [NUM_CH][2];
  logic [REC_W-1:0] mem_q    [NUM_CH][2][DEPTH];
  logic [PTR_W-1:0] wr_q     [NUM_CH][2];
  logic [PTR_W-1:0] wr_d     [NUM_CH][2];
  logic [PTR_W-1:0] rd_q     [NUM_CH][2];
  logic [PTR_W-1:0] rd_d     [NUM_CH][2];
  logic             rdy_q    [NUM_CH][2];
  logic             rdy_d    [NUM_CH][2];
  logic [7:0]       stall_q  [NUM_CH][2];
  logic [7:0]       stall_d  [NUM_CH][2];
  logic             stall_now[NUM_CH][2];
  logic             push     [NUM_CH][2];
  logic             empty    [NUM_CH][2];
  logic [REC_W-1:0] head     [NUM_CH][2];

  logic [NUM_CH-1:0] fire, mis;
  logic [NUM_CH-1:0] fire_p1, mis_p1;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] errch_q, errch_d;
  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic [CNT_W-1:0]  err_q, err_d;

  function automatic logic [SUM_W-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + SUM_W'(v[i]);
    return n;
  endfunction

  // The sum is formed wide enough to hold any single-cycle increment, then clamped.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + inc;
    if (s > CNT_MAX) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // ---- stage 0: FIFO heads, push/pop decisions and compare ----
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      vld_in[c][0] = tap.mst_valid[c];
      vld_in[c][1] = tap.slv_valid[c];
      rec_in[c][0] = tap.mst_rec[c*REC_W +: REC_W];
      rec_in[c][1] = tap.slv_rec[c*REC_W +: REC_W];
      for (int s = 0; s < 2; s++) begin
        empty[c][s]     = (wr_q[c][s] == rd_q[c][s]);
        head[c][s]      = mem_q[c][s][rd_q[c][s][AW-1:0]];
        // ready is the registered !full, so a full FIFO never accepts even if it pops now
        push[c][s]      = vld_in[c][s] && rdy_q[c][s] && !clr;
        stall_now[c][s] = vld_in[c][s] && !rdy_q[c][s];
      end
      fire[c] = !empty[c][0] && !empty[c][1] && !clr;
      mis[c]  = (head[c][0] != head[c][1]);
    end
  end

  always_comb begin
    ovf_d = clr ? '0 : ovf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 2; s++) begin
        wr_d[c][s]  = clr ? '0 : wr_q[c][s] + PTR_W'(push[c][s]);
        rd_d[c][s]  = clr ? '0 : rd_q[c][s] + PTR_W'(fire[c]);
        // full when the indices match but the wrap bits differ
        rdy_d[c][s] = !((wr_d[c][s][AW] != rd_d[c][s][AW]) &&
                        (wr_d[c][s][AW-1:0] == rd_d[c][s][AW-1:0]));
        if (clr || !stall_now[c][s]) begin
          stall_d[c][s] = 8'd0;
        end else if (stall_q[c][s] == 8'hFF) begin
          stall_d[c][s] = 8'hFF;
        end else begin
          stall_d[c][s] = stall_q[c][s] + 8'd1;
        end
        // 255 prior stalled cycles plus this one makes 256 consecutive
        if (!clr && stall_now[c][s] && (stall_q[c][s] == 8'hFF)) ovf_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (push[c][s]) mem_q[c][s][wr_q[c][s][AW-1:0]] <= rec_in[c][s];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < 2; s++) begin
          wr_q[c][s]    <= '0;
          rd_q[c][s]    <= '0;
          rdy_q[c][s]   <= 1'b1;
          stall_q[c][s] <= 8'd0;
        end
      end
      ovf_q   <= '0;
      fire_p1 <= '0;
      mis_p1  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < 2; s++) begin
          wr_q[c][s]    <= wr_d[c][s];
          rd_q[c][s]    <= rd_d[c][s];
          rdy_q[c][s]   <= rdy_d[c][s];
          stall_q[c][s] <= stall_d[c][s];
        end
      end
      ovf_q   <= ovf_d;
      fire_p1 <= fire;
      mis_p1  <= mis & fire;
    end
  end

  // ---- stage 1: registered compare results fold into counters and flags ----
  always_comb begin
    cmp_d   = clr ? '0 : sat_add(cmp_q, popcnt(fire_p1));
    err_d   = clr ? '0 : sat_add(err_q, popcnt(fire_p1 & mis_p1));
    errch_d = clr ? '0 : (errch_q | (fire_p1 & mis_p1));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmp_q   <= '0;
      err_q   <= '0;
      errch_q <= '0;
    end else begin
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      errch_q <= errch_d;
    end
  end

  always_comb begin
    idle = ~|fire_p1;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (!empty[c][s]) idle = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_rdy
    assign tap.mst_ready[c] = rdy_q[c][0];
    assign tap.slv_ready[c] = rdy_q[c][1];
  end

  assign cmp_cnt = cmp_q;
  assign err_cnt = err_q;
  assign err_ch  = errch_q;
  assign ovf     = ovf_q;

`ifdef SCB_FIRST_ERR_CAPTURE_EN
  logic [REC_W-1:0]   rec_p1 [NUM_CH][2];
  logic [NUM_CH-1:0]  hit;
  logic               fe_valid_q, fe_valid_d;
  logic [FE_CH_W-1:0] fe_ch_q, fe_ch_d;
  logic [REC_W-1:0]   fe_mst_q, fe_mst_d;
  logic [REC_W-1:0]   fe_slv_q, fe_slv_d;

  // Popped heads travel alongside fire_p1 so the capture sees the compared pair.
  always_ff @(posedge aclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (fire[c]) begin
        rec_p1[c][0] <= head[c][0];
        rec_p1[c][1] <= head[c][1];
      end
    end
  end

  always_comb begin
    hit        = fire_p1 & mis_p1;
    fe_valid_d = fe_valid_q;
    fe_ch_d    = fe_ch_q;
    fe_mst_d   = fe_mst_q;
    fe_slv_d   = fe_slv_q;
    if (clr) begin
      fe_valid_d = 1'b0;
      fe_ch_d    = '0;
      fe_mst_d   = '0;
      fe_slv_d   = '0;
    end else if (!fe_valid_q && |hit) begin
      fe_valid_d = 1'b1;
      // descending scan so the lowest mismatching channel is the last written
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (hit[c]) begin
          fe_ch_d  = FE_CH_W'(c);
          fe_mst_d = rec_p1[c][0];
          fe_slv_d = rec_p1[c][1];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fe_valid_q <= 1'b0;
      fe_ch_q    <= '0;
      fe_mst_q   <= '0;
      fe_slv_q   <= '0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_ch_q    <= fe_ch_d;
      fe_mst_q   <= fe_mst_d;
      fe_slv_q   <= fe_slv_d;
    end
  end

  assign fe_valid = fe_valid_q;
  assign fe_ch    = fe_ch_q;
  assign fe_mst   = fe_mst_q;
  assign fe_slv   = fe_slv_q;
`else
  assign fe_valid = 1'b0;
  assign fe_ch    = '0;
  assign fe_mst   = '0;
  assign fe_slv   = '0;
`endif

endmodule
